// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // One register-file write: destination and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO holding long-latency register writes until the write port is free.
// Latency: an entry pushed on one edge is visible at dout after that edge.
// Backpressure: push is ignored while full, pop is ignored while empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output wb_req_t dout,
  output logic    full,
  output logic    empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  wb_req_t       mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array: written on accepted pushes only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges pipeline writeback (fixed priority) with buffered long-latency results onto one register-file write port.
// Latency: pipeline write 1 cycle; long-latency result 2 cycles minimum, +1 per competing pipeline write.
// Backpressure: l_ready drops while the FIFO is full; pipeline has none. Optional busy scoreboard under WB_SCOREBOARD_EN.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p_wr,
  input  logic [REG_ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0]     p_data,
  input  logic                  l_valid,
  output logic                  l_ready,
  input  logic [REG_ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0]     l_data,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  output logic                  busy_rs,
  output logic                  busy_rt,
  output logic                  wr,
  output logic [REG_ADDR_W-1:0] addr3,
  output logic [DATA_W-1:0]     data3
);

  logic    p_win;
  logic    fifo_full;
  logic    fifo_empty;
  logic    fifo_push;
  logic    fifo_pop;
  wb_req_t fifo_in;
  wb_req_t fifo_head;

  // Writes to $0 are dropped on both paths; a dropped pipeline write lets the FIFO pop.
  assign p_win     = p_wr && (p_addr != '0);
  assign l_ready   = !fifo_full;
  assign fifo_push = l_valid && l_ready && (l_addr != '0);
  assign fifo_pop  = !p_win && !fifo_empty;
  assign fifo_in   = '{addr: l_addr, data: l_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_in),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Output register: pipeline first, then FIFO head; address and data hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr    <= 1'b0;
      addr3 <= '0;
      data3 <= '0;
    end else if (p_win) begin
      wr    <= 1'b1;
      addr3 <= p_addr;
      data3 <= p_data;
    end else if (fifo_pop) begin
      wr    <= 1'b1;
      addr3 <= fifo_head.addr;
      data3 <= fifo_head.data;
    end else begin
      wr    <= 1'b0;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy;
  logic [31:0] busy_next;

  // Clear on pop of a matching entry, then set on issue so a same-cycle issue wins; bit 0 never set.
  always_comb begin
    busy_next = busy;
    if (fifo_pop) busy_next[fifo_head.addr] = 1'b0;
    if (iss_valid && (iss_rd != '0)) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_next;
  end

  assign busy_rs = (rs != '0) && busy[rs];
  assign busy_rt = (rt != '0) && busy[rt];
`else
  logic unused_sb;
  assign unused_sb = ^{iss_valid, iss_rd, rs, rt};
  assign busy_rs   = 1'b0;
  assign busy_rt   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter with a queue-based reference model checked every cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_write_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 2;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  p_wr = 1'b0;
  logic [REG_ADDR_W-1:0] p_addr = '0;
  logic [DATA_W-1:0]     p_data = '0;
  logic                  l_valid = 1'b0;
  logic                  l_ready;
  logic [REG_ADDR_W-1:0] l_addr = '0;
  logic [DATA_W-1:0]     l_data = '0;
  logic                  iss_valid = 1'b0;
  logic [REG_ADDR_W-1:0] iss_rd = '0;
  logic [REG_ADDR_W-1:0] rs = '0;
  logic [REG_ADDR_W-1:0] rt = '0;
  logic                  busy_rs, busy_rt, wr;
  logic [REG_ADDR_W-1:0] addr3;
  logic [DATA_W-1:0]     data3;

  int tests = 0;
  int fails = 0;

  wb_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .p_wr(p_wr), .p_addr(p_addr), .p_data(p_data),
    .l_valid(l_valid), .l_ready(l_ready), .l_addr(l_addr), .l_data(l_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs(rs), .rt(rt),
    .busy_rs(busy_rs), .busy_rt(busy_rt), .wr(wr), .addr3(addr3), .data3(data3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending writes plus a 32-entry busy table.
  wb_req_t               mq[$];
  bit                    mbusy[32];
  logic                  m_wr = 1'b0;
  logic [REG_ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0]     m_data = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      m_wr = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      automatic int  sz = mq.size();
      automatic bit  accept = l_valid && (sz < DEPTH);
      automatic wb_req_t h;
      if (p_wr && p_addr != 0) begin
        m_wr = 1'b1; m_addr = p_addr; m_data = p_data;
      end else if (sz > 0) begin
        h = mq.pop_front();
        m_wr = 1'b1; m_addr = h.addr; m_data = h.data;
        mbusy[h.addr] = 1'b0;
      end else begin
        m_wr = 1'b0;
      end
      if (accept && l_addr != 0) mq.push_back('{addr: l_addr, data: l_data});
      if (iss_valid && iss_rd != 0) mbusy[iss_rd] = 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("m_wr", {31'd0, wr}, {31'd0, m_wr});
    chk("m_addr3", {27'd0, addr3}, {27'd0, m_addr});
    chk("m_data3", data3, m_data);
    chk("m_l_ready", {31'd0, l_ready}, {31'd0, (mq.size() < DEPTH)});
    chk("m_busy_rs", {31'd0, busy_rs}, {31'd0, SB && rs != 0 && mbusy[rs]});
    chk("m_busy_rt", {31'd0, busy_rt}, {31'd0, SB && rt != 0 && mbusy[rt]});
  end

  // Advance one clock; inputs change 2ns after the edge, registered outputs are settled.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #3 reset = 1'b0;
    cyc(); cyc();
    chk("rst_wr", {31'd0, wr}, 32'd0);
    chk("rst_addr3", {27'd0, addr3}, 32'd0);
    chk("rst_data3", data3, 32'd0);
    chk("rst_l_ready", {31'd0, l_ready}, 32'd1);
    reset = 1'b1;
    cyc();

    // Pipeline write
    p_wr = 1; p_addr = 5; p_data = 32'h1234;
    cyc();
    p_wr = 0;
    chk("pipe_wr", {31'd0, wr}, 32'd1);
    chk("pipe_addr3", {27'd0, addr3}, 32'd5);
    chk("pipe_data3", data3, 32'h1234);
    cyc();
    chk("pipe_idle_wr", {31'd0, wr}, 32'd0);
    chk("pipe_hold_addr3", {27'd0, addr3}, 32'd5);

    // Long-latency write: 2 cycles from transfer to wr
    l_valid = 1; l_addr = 9; l_data = 32'hCAFE;
    chk("ll_ready", {31'd0, l_ready}, 32'd1);
    cyc();
    l_valid = 0;
    chk("ll_wr_early", {31'd0, wr}, 32'd0);
    cyc();
    chk("ll_wr", {31'd0, wr}, 32'd1);
    chk("ll_addr3", {27'd0, addr3}, 32'd9);
    chk("ll_data3", data3, 32'hCAFE);
    cyc();

    // Fill and starve
    p_wr = 1; p_addr = 1; p_data = 32'h11;
    l_valid = 1; l_addr = 10; l_data = 32'hA0;
    cyc();
    l_addr = 11; l_data = 32'hB0;
    cyc();
    l_addr = 12; l_data = 32'hC0;
    for (int i = 0; i < 3; i++) begin
      chk("starve_l_ready", {31'd0, l_ready}, 32'd0);
      cyc();
      chk("starve_addr3", {27'd0, addr3}, 32'd1);
    end
    p_wr = 0;
    cyc();
    chk("drain0_addr3", {27'd0, addr3}, 32'd10);
    chk("drain0_data3", data3, 32'hA0);
    chk("drain0_l_ready", {31'd0, l_ready}, 32'd1);
    cyc();
    l_valid = 0;
    chk("drain1_addr3", {27'd0, addr3}, 32'd11);
    cyc();
    chk("drain2_wr", {31'd0, wr}, 32'd1);
    chk("drain2_addr3", {27'd0, addr3}, 32'd12);
    chk("drain2_data3", data3, 32'hC0);
    cyc();

    // Writes to $0
    p_wr = 1; p_addr = 0; p_data = 32'hDEAD;
    cyc();
    p_wr = 0;
    chk("zero_p_wr", {31'd0, wr}, 32'd0);
    l_valid = 1; l_addr = 0; l_data = 32'hBEEF;
    chk("zero_l_ready", {31'd0, l_ready}, 32'd1);
    cyc();
    l_valid = 0;
    cyc();
    chk("zero_l_wr", {31'd0, wr}, 32'd0);
    // A $0 pipeline write lets a queued entry pop
    p_wr = 1; p_addr = 2; p_data = 32'h22;
    l_valid = 1; l_addr = 4; l_data = 32'h44;
    cyc();
    l_valid = 0; p_addr = 0;
    cyc();
    p_wr = 0;
    chk("zero_pop_addr3", {27'd0, addr3}, 32'd4);
    chk("zero_pop_data3", data3, 32'h44);
    cyc();

    // Scoreboard: issue r7, pop clears it
    iss_valid = 1; iss_rd = 7; rs = 7;
    cyc();
    iss_valid = 0;
    chk("sb_set", {31'd0, busy_rs}, {31'd0, SB});
    p_wr = 1; p_addr = 2; p_data = 32'h2;
    l_valid = 1; l_addr = 7; l_data = 32'h77;
    cyc();
    l_valid = 0;
    cyc();
    chk("sb_pending", {31'd0, busy_rs}, {31'd0, SB});
    p_wr = 0;
    cyc();
    chk("sb_clear_addr3", {27'd0, addr3}, 32'd7);
    chk("sb_clear", {31'd0, busy_rs}, 32'd0);
    // Issue and pop of r7 in the same cycle: set wins
    p_wr = 1; l_valid = 1; l_addr = 7; l_data = 32'h78;
    cyc();
    l_valid = 0; p_wr = 0; iss_valid = 1; iss_rd = 7;
    cyc();
    iss_valid = 0;
    chk("sb_same_addr3", {27'd0, addr3}, 32'd7);
    chk("sb_same_busy", {31'd0, busy_rs}, {31'd0, SB});
    cyc();

    // Reset mid-operation
    p_wr = 1; p_addr = 1; iss_valid = 1; iss_rd = 3; rt = 3;
    l_valid = 1; l_addr = 20; l_data = 32'h20;
    cyc();
    iss_valid = 0; l_addr = 21; l_data = 32'h21;
    cyc();
    l_valid = 0;
    chk("pre_rst_full", {31'd0, l_ready}, 32'd0);
    chk("pre_rst_busy", {31'd0, busy_rt}, {31'd0, SB});
    p_wr = 0;
    reset = 0;
    #1;
    chk("mid_rst_wr", {31'd0, wr}, 32'd0);
    chk("mid_rst_l_ready", {31'd0, l_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy_rt}, 32'd0);
    cyc();
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("post_rst_wr", {31'd0, wr}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

- Writer-side front end for the CPU register file's single write port (`wr`, `addr3`, `data3`).
- Merges two sources of register writes:
  - pipeline writeback, which has fixed priority;
  - a long-latency result source (mul/div, delayed load), buffered in a small FIFO with a valid/ready handshake.
- Optionally keeps a per-register busy scoreboard so decode can stall on results that have not yet been written.

## Interface
- `DEPTH`, default 2: long-latency FIFO entries; power of 2, ≥2.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `p_wr` in 1: pipeline writeback request; no backpressure.
- `p_addr` in 5: pipeline destination register.
- `p_data` in 32: pipeline write data.
- `l_valid` in 1: long-latency result valid.
- `l_ready` out 1: FIFO can accept a result.
- `l_addr` in 5: long-latency destination register.
- `l_data` in 32: long-latency write data.
- `iss_valid` in 1: long-latency operation issued this cycle.
- `iss_rd` in 5: destination register of the issued operation.
- `rs`, `rt` in 5 each: decode source registers.
- `busy_rs`, `busy_rt` out 1 each: source register has a pending long-latency write.
- `wr` out 1: register-file write enable, registered.
- `addr3` out 5: register-file write address, registered.
- `data3` out 32: register-file write data, registered.

## Operation
**Handshake and FIFO**
- A transfer occurs when `l_valid && l_ready`.
- `l_ready` = FIFO count < `DEPTH`, using the count at the start of the cycle. A pop in the same cycle does not free a slot for a push when the FIFO is full.
- A transfer with `l_addr==0` is accepted and discarded. No FIFO entry is written.

**Output register** (loaded every cycle)
- If `p_wr && p_addr!=0`: load `wr=1`, `addr3=p_addr`, `data3=p_data`.
- Else, if the FIFO is non-empty: pop the head and load `wr=1` with its address and data.
- Else: `wr=0`. `addr3` and `data3` hold their previous values.
- A pipeline write to `$0` is dropped. The FIFO may pop in that cycle.

**Ordering**
- Writes are committed in arbitration order. There is no merging or coalescing.
- Continuous pipeline writes starve the FIFO. Once the FIFO fills, `l_ready` stays low; no entry is lost.

**Scoreboard**
- `busy[31:1]`:
  - set on `iss_valid && iss_rd!=0`;
  - cleared when a FIFO entry with that address is popped into the output register.
- A set and a clear of the same register in the same cycle: set wins.
- `busy_rs` = (`rs!=0`) & `busy[rs]`, combinational. `busy_rt` is formed the same way.
- In the cycle after the clear, `wr=1` presents the value. Consumers obtain it through the register file's write-port forwarding.

## Timing
**Reset**
- `wr=0`, `addr3=0`, `data3=0`.
- FIFO empty, so `l_ready=1`.
- All busy bits 0, so `busy_rs=busy_rt=0`.

**Latency**
- Pipeline write to `wr`: 1 cycle.
- Long-latency transfer to `wr`: 2 cycles minimum (push edge, then pop edge). Add 1 cycle for each competing pipeline write.

**Boundaries**
- Full FIFO plus `l_valid`: no transfer. The source holds its data.
- Empty FIFO: no pop, no underflow.
- Pointers wrap modulo `DEPTH`.
- Reset asserted mid-operation: FIFO, scoreboard and output register are cleared immediately. Pending writes are lost.

## Configuration
- `WB_SCOREBOARD_EN` defined: the busy scoreboard is built as described above.
- `WB_SCOREBOARD_EN` undefined:
  - no busy storage;
  - `busy_rs=busy_rt=0`;
  - `iss_valid` and `iss_rd` are ignored.
- Arbitration and FIFO behaviour are identical in both builds.

## Structure
- Package `wb_pkg`:
  - `REG_ADDR_W=5`, `DATA_W=32`;
  - typedef `wb_req_t` {addr, data}.
- Sub-module `wb_fifo`:
  - parameter `DEPTH`;
  - ports: push, pop, `wb_req_t` in/out, `full`, `empty`.
- Arbitration, output register and scoreboard sit in the top level.

## Test plan
- **Pipeline write:** `p_wr=1`, `p_addr=5`, `p_data=0x1234` for one cycle -> next cycle `wr=1`, `addr3=5`, `data3=0x1234`; the cycle after, `wr=0`.
- **Long-latency write:** `l_valid`, `l_addr=9`, `l_data=0xCAFE` with the pipeline idle -> `wr=1`, `addr3=9` exactly 2 cycles after the transfer.
- **Fill and starve (`DEPTH=2`):** continuous `p_wr` to `r1` while pushing 3 results -> 2 accepted, then `l_ready=0`. Release `p_wr` -> both FIFO writes follow in push order on consecutive cycles.
- **Writes to `$0`:** `p_wr` with `p_addr=0` -> `wr=0`. `l_addr=0` transfer -> accepted, never appears on `wr`.
- **Scoreboard:** issue `rd=7`, then `rs=7` -> `busy_rs=1` until the pop edge of the `r7` entry, then 0, with `wr=1`, `addr3=7` in that cycle. Issue and pop of `r7` in the same cycle -> busy stays 1.
- **Reset mid-operation:** reset with 2 entries queued and `busy[3]` set -> `wr=0`, `l_ready=1`, `busy_rt(rt=3)=0`; nothing is written after reset is released.
